program_loader: RTL and testbench

- Writer side of program memory: receives a byte stream and writes instruction words into program memory, which the fetch path reads and feeds to the instruction decoder.
- Holds the CPU core (fetch/decode/execute) in hold while loading.
- Reports Done or Err on completion.
- Sits between the host byte link (UART receiver or testbench) and the program-memory write port.

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/program_loader_checksum.sv | 26 ++
 rtl/program_loader.sv | 139 +++++++++++++
 tb/tb_program_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: default widths, byte constants and FSM states.
// Optional checksum support is enabled by PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

    localparam int INS_W_DEF  = 13;
    localparam int ADDR_W_DEF = 8;
    localparam int BYTE_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        CNT,
        HI,
        LO,
        WR,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    // Bits of the HI byte that carry instruction bits; the rest must be zero.
    function automatic logic [BYTE_W-1:0] hi_mask(input int ins_w);
        return 8'((16'd1 << (ins_w - BYTE_W)) - 16'd1);
    endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// 8-bit modular accumulator for the loader byte stream, with a zero check against a final byte.
// Instantiated only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module loader_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic       sum_zero
);

    logic [7:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'd0;
        end else if (clr) begin
            sum <= 8'd0;
        end else if (add) begin
            sum <= 8'(sum + din);
        end
    end

    assign sum_zero = (8'(sum + din) == 8'd0);

endmodule

// File: rtl/program_loader.sv
// Writes a host byte stream (count, then HI/LO byte pairs) into program memory while holding the core.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing checksum byte before Done.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INS_W  = INS_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              Ld_Start,
    input  logic [7:0]        Rx_Data,
    input  logic              Rx_Valid,
    output logic              Rx_Ready,
    output logic              PM_WE,
    output logic [ADDR_W-1:0] PM_Addr,
    output logic [INS_W-1:0]  PM_Data,
    output logic              CPU_nHold,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int          HI_BITS = INS_W - BYTE_W;
    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [7:0]  HI_MASK = hi_mask(INS_W);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic              xfer;
    logic              start;
    logic              cnt_bad;
    logic              hi_bad;

    assign xfer    = Rx_Valid & Rx_Ready;
    assign cnt_bad = (Rx_Data == 8'd0) || (32'(Rx_Data) > (32'd1 << ADDR_W));
    assign hi_bad  = |(Rx_Data & ~HI_MASK);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic sum_ok;

    loader_checksum u_checksum (
        .clk      (clk),
        .rst_n    (nReset),
        .clr      (start),
        .add      (xfer && (state == CNT || state == HI || state == LO)),
        .din      (Rx_Data),
        .sum_zero (sum_ok)
    );
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Rx_Ready  = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (Ld_Start) begin
                    start     = 1'b1;
                    state_nxt = CNT;
                end
            end
            CNT: begin
                Rx_Ready = 1'b1;
                if (xfer) state_nxt = cnt_bad ? ERR : HI;
            end
            HI: begin
                Rx_Ready = 1'b1;
                if (xfer) state_nxt = hi_bad ? ERR : LO;
            end
            LO: begin
                Rx_Ready = 1'b1;
                if (xfer) state_nxt = WR;
            end
            WR: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state_nxt = (count == CNT_W'(1)) ? CHK : HI;
`else
                state_nxt = (count == CNT_W'(1)) ? DONE : HI;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHK: begin
                Rx_Ready = 1'b1;
                if (xfer) state_nxt = sum_ok ? DONE : ERR;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags are registered on the transition so they line up with the new state.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            PM_WE     <= 1'b0;
            PM_Addr   <= '0;
            PM_Data   <= '0;
            CPU_nHold <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
            count     <= '0;
        end else begin
            PM_WE <= (state == LO) && xfer;
            if (start) begin
                Done      <= 1'b0;
                Err       <= 1'b0;
                PM_Addr   <= '0;
                CPU_nHold <= 1'b0;
                Busy      <= 1'b1;
            end
            if (state == CNT && xfer && !cnt_bad) count <= CNT_W'(Rx_Data);
            if (state == HI && xfer) PM_Data[INS_W-1:BYTE_W] <= Rx_Data[HI_BITS-1:0];
            if (state == LO && xfer) PM_Data[BYTE_W-1:0] <= Rx_Data;
            if (state == WR) begin
                PM_Addr <= PM_Addr + ADDR_W'(1);
                count   <= count - CNT_W'(1);
            end
            if (state_nxt == DONE && state != DONE) begin
                Done      <= 1'b1;
                Busy      <= 1'b0;
                CPU_nHold <= 1'b1;
            end
            if (state_nxt == ERR && state != ERR) begin
                Err  <= 1'b1;
                Busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the stimulus and
// popped by a write monitor. Covers checksum sessions when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int INS_W  = 13;
    localparam int ADDR_W = 8;
    localparam int EW     = ADDR_W + INS_W;

    logic              clk = 1'b0;
    logic              nReset;
    logic              Ld_Start;
    logic [7:0]        Rx_Data;
    logic              Rx_Valid;
    logic              Rx_Ready;
    logic              PM_WE;
    logic [ADDR_W-1:0] PM_Addr;
    logic [INS_W-1:0]  PM_Data;
    logic              CPU_nHold;
    logic              Busy;
    logic              Done;
    logic              Err;

    int                tests = 0;
    int                fails = 0;
    logic [EW-1:0]     exp_q[$];
    logic [7:0]        byte_q[$];
    logic [7:0]        sum;
    logic [ADDR_W-1:0] next_addr;

    program_loader #(.INS_W(INS_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .Ld_Start  (Ld_Start),
        .Rx_Data   (Rx_Data),
        .Rx_Valid  (Rx_Valid),
        .Rx_Ready  (Rx_Ready),
        .PM_WE     (PM_WE),
        .PM_Addr   (PM_Addr),
        .PM_Data   (PM_Data),
        .CPU_nHold (CPU_nHold),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (nReset === 1'b1 && PM_WE === 1'b1) begin
            check("wr_rx_ready", {31'd0, Rx_Ready}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", PM_Addr, PM_Data);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {24'd0, PM_Addr}, {24'd0, e[EW-1:INS_W]});
                check("wr_data", {19'd0, PM_Data}, {19'd0, e[INS_W-1:0]});
            end
        end
    end

    task automatic pulse_start();
        Ld_Start = 1'b1;
        @(negedge clk);
        Ld_Start = 1'b0;
    endtask

    task automatic new_stream(input logic [7:0] n);
        byte_q    = {};
        byte_q.push_back(n);
        sum       = n;
        next_addr = '0;
    endtask

    task automatic add_word(input logic [15:0] w);
        byte_q.push_back(w[15:8]);
        byte_q.push_back(w[7:0]);
        sum = 8'(sum + w[15:8] + w[7:0]);
        exp_q.push_back({next_addr, w[INS_W-1:0]});
        next_addr = next_addr + 1'b1;
    endtask

    task automatic add_checksum(input bit good);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = 8'(8'd0 - sum);
        if (!good) c = 8'(c - 8'd1);
        byte_q.push_back(c);
`else
        if (good) sum = sum;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        Rx_Valid = 1'b0;
        repeat (gap) @(negedge clk);
        Rx_Valid = 1'b1;
        Rx_Data  = b;
        tries    = 0;
        while (Rx_Ready !== 1'b1 && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        check("handshake_timeout", {31'd0, (tries >= 100)}, 32'd0);
        @(negedge clk);
        Rx_Valid = 1'b0;
        Rx_Data  = 8'h00;
    endtask

    task automatic send_stream(input int max_gap, input int start_at);
        for (int i = 0; i < byte_q.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(byte_q[i], int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic end_check(input string tag, input bit d, input bit e, input bit h);
        int tries;
        tries = 0;
        while (Busy === 1'b1 && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        check({tag, "_busy"},  {31'd0, Busy},      32'd0);
        check({tag, "_done"},  {31'd0, Done},      {31'd0, d});
        check({tag, "_err"},   {31'd0, Err},       {31'd0, e});
        check({tag, "_nhold"}, {31'd0, CPU_nHold}, {31'd0, h});
        check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, {31'd0, Rx_Ready},  32'd0);
        check({tag, "_pm_we"},    {31'd0, PM_WE},     32'd0);
        check({tag, "_pm_addr"},  {24'd0, PM_Addr},   32'd0);
        check({tag, "_pm_data"},  {19'd0, PM_Data},   32'd0);
        check({tag, "_nhold"},    {31'd0, CPU_nHold}, 32'd1);
        check({tag, "_busy"},     {31'd0, Busy},      32'd0);
        check({tag, "_done"},     {31'd0, Done},      32'd0);
        check({tag, "_err"},      {31'd0, Err},       32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nReset   = 1'b0;
        Ld_Start = 1'b0;
        Rx_Valid = 1'b0;
        Rx_Data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        nReset = 1'b1;
        @(negedge clk);

        // Basic two-word load
        pulse_start();
        check("start_busy",  {31'd0, Busy},      32'd1);
        check("start_nhold", {31'd0, CPU_nHold}, 32'd0);
        new_stream(8'h02);
        add_word(16'h1A05);
        add_word(16'h03FF);
        add_checksum(1'b1);
        send_stream(0, -1);
        end_check("basic", 1'b1, 1'b0, 1'b1);
        check("basic_final_addr", {24'd0, PM_Addr}, 32'd2);

        // Zero count
        pulse_start();
        new_stream(8'h00);
        send_stream(0, -1);
        end_check("zero", 1'b0, 1'b1, 1'b0);

        // Illegal bits above the 13-bit instruction in the HI byte
        pulse_start();
        new_stream(8'h01);
        byte_q.push_back(8'h20);
        send_stream(0, -1);
        end_check("illegal_hi", 1'b0, 1'b1, 1'b0);

        // Widest legal HI byte and all-zero word
        pulse_start();
        new_stream(8'h03);
        add_word(16'h1FFF);
        add_word(16'h0000);
        add_word(16'h1000);
        add_checksum(1'b1);
        send_stream(0, -1);
        end_check("boundary", 1'b1, 1'b0, 1'b1);
        check("boundary_final_addr", {24'd0, PM_Addr}, 32'd3);

        // Idle gaps on Rx_Valid plus an ignored Ld_Start mid-session
        pulse_start();
        new_stream(8'h02);
        add_word(16'h1A05);
        add_word(16'h03FF);
        add_checksum(1'b1);
        send_stream(4, 3);
        end_check("gaps", 1'b1, 1'b0, 1'b1);

        // Reset after the second word's HI byte
        pulse_start();
        new_stream(8'h02);
        add_word(16'h0102);
        byte_q.push_back(8'h03);
        send_stream(0, -1);
        nReset = 1'b0;
        #1;
        check_reset_vals("midreset");
        check("midreset_pending_writes", exp_q.size(), 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        pulse_start();
        new_stream(8'h01);
        add_word(16'h0ABC);
        add_checksum(1'b1);
        send_stream(0, -1);
        end_check("reload", 1'b1, 1'b0, 1'b1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        pulse_start();
        new_stream(8'h01);
        add_word(16'h0010);
        check("chk_good_byte", {24'd0, 8'(8'd0 - sum)}, 32'hEF);
        add_checksum(1'b1);
        send_stream(0, -1);
        end_check("chk_good", 1'b1, 1'b0, 1'b1);

        pulse_start();
        new_stream(8'h01);
        add_word(16'h0010);
        add_checksum(1'b0);
        send_stream(0, -1);
        end_check("chk_bad", 1'b0, 1'b1, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("final_pending_writes", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
